knight_ctrl: RTL
================

# knight_ctrl

Sequencer for the knight-rider scanner chain (`knight6`-family shift registers with `up`/`iup`/`ilow` controls). It generates the direction, injection and step-enable signals so a single lit stage sweeps the chain at a programmable rate. Supported patterns are bounce with end dwell, up-only wrap and down-only wrap. It sits between the board-level mode and speed registers and the chain, replacing hand-driven stimulus.

## Interface
Parameters:
- `N`, 6: number of chain stages.
- `PW`, 8: prescaler width.
- `DWELL`, 2: ticks held at each end in bounce mode (0 allowed).

Ports:
- `ck`, in, 1: clock, shared with the chain.
- `res`, in, 1: reset, synchronous, active-high.
- `en`, in, 1: run request, level-sensitive.
- `div`, in, PW: step period minus 1, in `ck` cycles.
- `mode`, in, 2: 00 bounce, 01 up-only, 10 down-only, 11 treated as bounce.
- `stp`, out, 1: chain advances only on cycles with `stp`=1.
- `up`, out, 1: shift direction (1 = toward stage N-1).
- `iup`, out, 1: inject a 1 into stage 0 on this step.
- `ilow`, out, 1: inject a 1 into stage N-1 on this step.
- `clr`, out, 1: one-cycle pulse; the chain must reset.
- `pos`, out, $clog2(N): lit stage after the current or last step.
- `busy`, out, 1: not IDLE.

## Operation
- **States:** IDLE, INJ, RUN, DWELL.
- **Prescaler:**
  - `cnt` counts 0..`div` while not IDLE; `tick` = (`cnt`==`div`).
  - `div` is sampled only when `cnt` wraps.
- **IDLE → INJ:** on `en`=1. Mode is latched here; a `mode` change takes effect only after returning to IDLE.
- **INJ, on tick:**
  - `stp`=1.
  - Up-only or bounce: `up`=1, `iup`=1, `pos`=0.
  - Down-only: `up`=0, `ilow`=1, `pos`=N-1.
  - Then → RUN.
- **RUN, on tick:** `stp`=1, and `pos` moves one stage in direction `up`.
- **Bounce:**
  - When `pos` reaches N-1 (up) or 0 (down), → DWELL.
  - After DWELL ticks with `stp`=0, `up` toggles and the FSM returns to RUN.
  - If DWELL=0, turn around directly.
  - No re-injection occurs.
- **Up-only:** the step after `pos`=N-1 asserts `iup`=1 with `pos`=0 (old light exits, new light enters).
- **Down-only:** mirror of up-only, using `ilow` and `pos`=N-1.
- **Stop:** `en`=0 in any non-IDLE state → IDLE on the next edge, with a `clr` pulse for one cycle and `stp`=0.
- **`res`:** dominates `en`.
- **Simultaneous events:** `en` falling on a tick cycle has priority; no `stp` is issued.

## Timing
- **Reset values:** `stp`=0, `up`=1, `iup`=0, `ilow`=0, `clr`=0, `pos`=0, `busy`=0, `cnt`=0, state IDLE.
- **Registered outputs:** all outputs are registered. `up`, `iup`, `ilow` and `pos` are valid in the same cycle as `stp` and change only in the cycle after an `stp` cycle, or on a state entry.
- **Injection latency:** first `stp` (the inject) occurs `div`+1 cycles after the edge that samples `en`=1.
- **Step period:** `div`+1 cycles; `div`=0 gives `stp` every cycle.
- **Bounce period:** 2·(N-1+DWELL) ticks.
- **Stop latency:** `clr` is asserted exactly one cycle, in the cycle after `en` is sampled low.
- **Reset mid-scan:** no `clr` pulse; the chain shares `res`.

## Structure
- **Shared package `knight_pkg`:**
  - state enum;
  - mode encodings `KM_BOUNCE`, `KM_UP`, `KM_DOWN`;
  - default `N`.
- **Sub-module `knight_presc`:** `cnt`/`div` reload logic producing `tick`.
- **FSM and position counter:** inline in `knight_ctrl`.

## Test plan
- **Reset:** `res`=1 for 1 edge mid-RUN → all outputs at reset values next cycle; `busy`=0.
- **Bounce:** `div`=0, `mode`=00, `en`=1 → inject at `pos` 0 with `iup`=1, then `pos` 1..5 with `up`=1, 2 cycles `stp`=0, `pos` 4..0 with `up`=0, 2 idle cycles, `pos` 1 with no `iup`.
- **Prescaler:** `div`=3 → `stp` exactly every 4th cycle. Change `div` to 1 mid-count → new period only after the current wrap.
- **Up-only:** `mode`=01 → `pos` 0..5, then next step `iup`=1 and `pos`=0, with no dwell gap.
- **Down-only:** `mode`=10 → `ilow`=1 with `pos`=5, `up`=0 throughout, wrap 0 → 5 with `ilow`.
- **Stop/restart:** drop `en` at `pos`=3 → one `clr` pulse, no further `stp`, `busy`=0. Raise `en` → fresh inject at `pos` 0.

Source files
------------

// File: rtl/knight_pkg.sv
// Shared types and constants for the knight-rider scanner sequencer.
package knight_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        StIdle,
        StInj,
        StRun,
        StDwell
    } knight_state_e;

    // Pattern encodings on the mode input
    localparam logic [1:0] KM_BOUNCE = 2'b00;
    localparam logic [1:0] KM_UP     = 2'b01;
    localparam logic [1:0] KM_DOWN   = 2'b10;

    // Default chain length
    localparam int unsigned KNIGHT_N = 6;

    // The unused encoding 11 behaves as bounce
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == KM_UP || m == KM_DOWN) ? m : KM_BOUNCE;
    endfunction

endpackage

// File: rtl/knight_presc.sv
// Step-rate prescaler: counts 0..div and flags the last count as a tick.
// The period is reloaded only at a wrap, so a div change never truncates
// or stretches the step already in progress.
module knight_presc #(
    parameter int unsigned PW = 8
) (
    input  logic          ck,
    input  logic          res,
    input  logic          run,
    input  logic [PW-1:0] div,
    output logic          tick
);

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] div_q;

    assign tick = run && (cnt_q == div_q);

    // Counter and period latch; held at zero / tracking div while stopped
    always_ff @(posedge ck) begin
        if (res) begin
            cnt_q <= '0;
            div_q <= '0;
        end else if (!run || tick) begin
            cnt_q <= '0;
            div_q <= div;
        end else begin
            cnt_q <= cnt_q + PW'(1);
        end
    end

endmodule

// File: rtl/knight_ctrl.sv
// Knight-rider chain sequencer: drives stp/up/iup/ilow so a single lit
// stage sweeps the chain in bounce, up-only or down-only pattern.
// All outputs are registered; their next values are built combinationally.
module knight_ctrl
    import knight_pkg::*;
#(
    parameter int unsigned N     = KNIGHT_N,
    parameter int unsigned PW    = 8,
    parameter int unsigned DWELL = 2
) (
    input  logic                 ck,
    input  logic                 res,
    input  logic                 en,
    input  logic [PW-1:0]        div,
    input  logic [1:0]           mode,
    output logic                 stp,
    output logic                 up,
    output logic                 iup,
    output logic                 ilow,
    output logic                 clr,
    output logic [$clog2(N)-1:0] pos,
    output logic                 busy
);

    localparam int unsigned PosW = $clog2(N);
    localparam int unsigned DW   = (DWELL > 0) ? $clog2(DWELL + 1) : 1;
    localparam logic [PosW-1:0] PLast = PosW'(N - 1);
    localparam logic [DW-1:0]   DLast = DW'((DWELL > 0) ? DWELL - 1 : 0);

    knight_state_e   state_q, state_d;
    logic [1:0]      mode_q, mode_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic            stp_q, stp_d;
    logic            up_q, up_d;
    logic            iup_q, iup_d;
    logic            ilow_q, ilow_d;
    logic            clr_q, clr_d;
    logic [PosW-1:0] pos_q, pos_d;
    logic            busy_q, busy_d;

    logic            tick;
    logic            turn_now;
    logic            dir;
    logic [PosW-1:0] bounce_pos;
    logic            land_end;

    knight_presc #(
        .PW (PW)
    ) u_presc (
        .ck   (ck),
        .res  (res),
        .run  (state_q != StIdle),
        .div  (div),
        .tick (tick)
    );

    // Bounce stepping: reverse in place when already at an end (only
    // reachable with no dwell), and flag a step that lands on an end.
    always_comb begin
        turn_now   = up_q ? (pos_q == PLast) : (pos_q == '0);
        dir        = turn_now ? !up_q : up_q;
        bounce_pos = dir ? pos_q + PosW'(1) : pos_q - PosW'(1);
        land_end   = dir ? (bounce_pos == PLast) : (bounce_pos == '0);
    end

    // State register and registered outputs
    always_ff @(posedge ck) begin
        if (res) begin
            state_q <= StIdle;
            mode_q  <= KM_BOUNCE;
            dcnt_q  <= '0;
            stp_q   <= 1'b0;
            up_q    <= 1'b1;
            iup_q   <= 1'b0;
            ilow_q  <= 1'b0;
            clr_q   <= 1'b0;
            pos_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            dcnt_q  <= dcnt_d;
            stp_q   <= stp_d;
            up_q    <= up_d;
            iup_q   <= iup_d;
            ilow_q  <= ilow_d;
            clr_q   <= clr_d;
            pos_q   <= pos_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic; a dropped run request beats a coincident tick
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (en) state_d = StInj;
            end
            StInj: begin
                if (!en)       state_d = StIdle;
                else if (tick) state_d = StRun;
            end
            StRun: begin
                if (!en) begin
                    state_d = StIdle;
                end else if (tick && mode_q == KM_BOUNCE && land_end && DWELL > 0) begin
                    state_d = StDwell;
                end
            end
            StDwell: begin
                if (!en)                            state_d = StIdle;
                else if (tick && dcnt_q == DLast)   state_d = StRun;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output next values: step strobes, direction, injection and position
    always_comb begin
        mode_d = mode_q;
        dcnt_d = dcnt_q;
        stp_d  = 1'b0;
        up_d   = up_q;
        iup_d  = 1'b0;
        ilow_d = 1'b0;
        clr_d  = 1'b0;
        pos_d  = pos_q;
        busy_d = (state_d != StIdle);
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    mode_d = norm_mode(mode);
                    up_d   = (norm_mode(mode) != KM_DOWN);
                    dcnt_d = '0;
                end
            end
            StInj: begin
                if (!en) begin
                    clr_d = 1'b1;
                end else if (tick) begin
                    stp_d = 1'b1;
                    if (mode_q == KM_DOWN) begin
                        up_d   = 1'b0;
                        ilow_d = 1'b1;
                        pos_d  = PLast;
                    end else begin
                        up_d  = 1'b1;
                        iup_d = 1'b1;
                        pos_d = '0;
                    end
                end
            end
            StRun: begin
                if (!en) begin
                    clr_d = 1'b1;
                end else if (tick) begin
                    stp_d = 1'b1;
                    case (mode_q)
                        KM_UP: begin
                            up_d = 1'b1;
                            if (pos_q == PLast) begin
                                iup_d = 1'b1;
                                pos_d = '0;
                            end else begin
                                pos_d = pos_q + PosW'(1);
                            end
                        end
                        KM_DOWN: begin
                            up_d = 1'b0;
                            if (pos_q == '0) begin
                                ilow_d = 1'b1;
                                pos_d  = PLast;
                            end else begin
                                pos_d = pos_q - PosW'(1);
                            end
                        end
                        default: begin
                            up_d  = dir;
                            pos_d = bounce_pos;
                        end
                    endcase
                end
            end
            StDwell: begin
                if (!en) begin
                    clr_d = 1'b1;
                end else if (tick) begin
                    if (dcnt_q == DLast) begin
                        dcnt_d = '0;
                        up_d   = !up_q;
                    end else begin
                        dcnt_d = dcnt_q + DW'(1);
                    end
                end
            end
            default: begin
                clr_d = 1'b0;
            end
        endcase
    end

    assign stp  = stp_q;
    assign up   = up_q;
    assign iup  = iup_q;
    assign ilow = ilow_q;
    assign clr  = clr_q;
    assign pos  = pos_q;
    assign busy = busy_q;

endmodule
